// File: rtl/ds1302_ctrl.sv
// DS1302 RTC master: programs or fetches all seven BCD time registers over the
// 3-wire CE/SCLK/IO interface, one command+data byte pair per CE pulse.
module ds1302_ctrl #(
   parameter int CLK_DIV = 50,
   parameter int CE_GAP  = 400
) (
   input  logic       clk,
   input  logic       rst,
   output logic       ds1302_ce,
   output logic       ds1302_sclk,
   inout  logic       ds1302_io,
   input  logic       write_time_req,
   input  logic [7:0] write_second,
   input  logic [7:0] write_minute,
   input  logic [7:0] write_hour,
   input  logic [7:0] write_date,
   input  logic [7:0] write_month,
   input  logic [7:0] write_week,
   input  logic [7:0] write_year,
   output logic       write_time_ack,
   input  logic       read_time_req,
   output logic [7:0] read_second,
   output logic [7:0] read_minute,
   output logic [7:0] read_hour,
   output logic [7:0] read_date,
   output logic [7:0] read_month,
   output logic [7:0] read_week,
   output logic [7:0] read_year,
   output logic       read_time_ack
);

   typedef enum logic [2:0] {IDLE, WP_CLR, WR_REGS, RD_REGS, DONE} state_t;
   typedef enum logic [2:0] {X_IDLE, X_SETUP, X_HIGH, X_LOW, X_GAP} xstate_t;

   localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LOAD  = 16'(CE_GAP - 1);

   state_t      state, state_next;
   xstate_t     x_state, x_next;
   logic [15:0] cnt;
   logic        cnt_zero;
   logic [4:0]  bit_cnt;
   logic [15:0] sh;
   logic [7:0]  rx;
   logic        io_oe;
   logic        x_rd;
   logic        op_read;
   logic [2:0]  idx;
   logic        xfer_start, xfer_rd, xfer_done;
   logic [7:0]  xfer_cmd, xfer_data, wr_byte;
   logic [7:0]  wr_sec, wr_min, wr_hour, wr_date, wr_month, wr_week, wr_year;
   logic [7:0]  sd_sec, sd_min, sd_hour, sd_date, sd_month, sd_week;

   // Outgoing bits always come from sh[0]; a transfer shifts right on each SCLK fall.
   assign ds1302_io      = io_oe ? sh[0] : 1'bz;
   assign cnt_zero       = (cnt == 16'd0);
   assign xfer_done      = (x_state == X_GAP) && cnt_zero;
   assign write_time_ack = (state == DONE) && !op_read;
   assign read_time_ack  = (state == DONE) && op_read;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         x_state <= X_IDLE;
      end else begin
         state   <= state_next;
         x_state <= x_next;
      end
   end

   always_comb begin
      case (idx)
         3'd0:    wr_byte = wr_sec & 8'h7F;
         3'd1:    wr_byte = wr_min;
         3'd2:    wr_byte = wr_hour;
         3'd3:    wr_byte = wr_date;
         3'd4:    wr_byte = wr_month;
         3'd5:    wr_byte = wr_week;
         default: wr_byte = wr_year;
      endcase
   end

   // Command byte is 0x80 + 2*index (+1 for read); index 7 is the control register.
   always_comb begin
      state_next = state;
      xfer_start = 1'b0;
      xfer_rd    = 1'b0;
      xfer_cmd   = 8'h00;
      xfer_data  = 8'h00;
      case (state)
         IDLE: begin
            if (write_time_req)     state_next = WP_CLR;
            else if (read_time_req) state_next = RD_REGS;
         end
         WP_CLR: begin
            xfer_start = (x_state == X_IDLE);
            xfer_cmd   = 8'h8E;
            if (xfer_done) state_next = WR_REGS;
         end
         WR_REGS: begin
            xfer_start = (x_state == X_IDLE);
            xfer_cmd   = {4'h8, idx, 1'b0};
            xfer_data  = wr_byte;
            if (xfer_done && idx == 3'd6) state_next = DONE;
         end
         RD_REGS: begin
            xfer_start = (x_state == X_IDLE);
            xfer_rd    = 1'b1;
            xfer_cmd   = {4'h8, idx, 1'b1};
            if (xfer_done && idx == 3'd6) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      x_next = x_state;
      case (x_state)
         X_IDLE:  if (xfer_start) x_next = X_SETUP;
         X_SETUP: if (cnt_zero) x_next = X_HIGH;
         X_HIGH:  if (cnt_zero) x_next = X_LOW;
         X_LOW:   if (cnt_zero) x_next = (bit_cnt == 5'd16) ? X_GAP : X_HIGH;
         X_GAP:   if (cnt_zero) x_next = X_IDLE;
         default: x_next = X_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ds1302_ce   <= 1'b0;
         ds1302_sclk <= 1'b0;
         io_oe       <= 1'b0;
         cnt         <= 16'd0;
         bit_cnt     <= 5'd0;
         sh          <= 16'd0;
         rx          <= 8'd0;
         x_rd        <= 1'b0;
      end else begin
         case (x_state)
            X_IDLE: begin
               if (xfer_start) begin
                  ds1302_ce   <= 1'b1;
                  ds1302_sclk <= 1'b0;
                  io_oe       <= 1'b1;
                  cnt         <= HALF_LOAD;
                  bit_cnt     <= 5'd0;
                  sh          <= {xfer_data, xfer_cmd};
                  x_rd        <= xfer_rd;
               end
            end
            X_SETUP: begin
               if (cnt_zero) begin
                  ds1302_sclk <= 1'b1;
                  cnt         <= HALF_LOAD;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            X_HIGH: begin
               if (cnt_zero) begin
                  ds1302_sclk <= 1'b0;
                  cnt         <= HALF_LOAD;
                  sh          <= {1'b0, sh[15:1]};
                  bit_cnt     <= bit_cnt + 5'd1;
                  // The slave takes over IO after the last command bit of a read.
                  if (x_rd && bit_cnt == 5'd7) io_oe <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            X_LOW: begin
               if (cnt_zero) begin
                  if (bit_cnt == 5'd16) begin
                     ds1302_ce <= 1'b0;
                     io_oe     <= 1'b0;
                     cnt       <= GAP_LOAD;
                  end else begin
                     ds1302_sclk <= 1'b1;
                     cnt         <= HALF_LOAD;
                     if (x_rd && bit_cnt[3]) rx <= {ds1302_io, rx[7:1]};
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            X_GAP: begin
               if (!cnt_zero) cnt <= cnt - 16'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_read     <= 1'b0;
         idx         <= 3'd0;
         wr_sec      <= 8'h00;
         wr_min      <= 8'h00;
         wr_hour     <= 8'h00;
         wr_date     <= 8'h00;
         wr_month    <= 8'h00;
         wr_week     <= 8'h00;
         wr_year     <= 8'h00;
         sd_sec      <= 8'h00;
         sd_min      <= 8'h00;
         sd_hour     <= 8'h00;
         sd_date     <= 8'h00;
         sd_month    <= 8'h00;
         sd_week     <= 8'h00;
         read_second <= 8'h00;
         read_minute <= 8'h00;
         read_hour   <= 8'h00;
         read_date   <= 8'h00;
         read_month  <= 8'h00;
         read_week   <= 8'h00;
         read_year   <= 8'h00;
      end else begin
         if (state == IDLE) begin
            idx <= 3'd0;
            if (write_time_req) begin
               op_read  <= 1'b0;
               wr_sec   <= write_second;
               wr_min   <= write_minute;
               wr_hour  <= write_hour;
               wr_date  <= write_date;
               wr_month <= write_month;
               wr_week  <= write_week;
               wr_year  <= write_year;
            end else if (read_time_req) begin
               op_read <= 1'b1;
            end
         end else if (xfer_done && state != WP_CLR) begin
            idx <= idx + 3'd1;
         end
         if (state == RD_REGS && xfer_done) begin
            case (idx)
               3'd0:    sd_sec   <= rx;
               3'd1:    sd_min   <= rx;
               3'd2:    sd_hour  <= rx;
               3'd3:    sd_date  <= rx;
               3'd4:    sd_month <= rx;
               3'd5:    sd_week  <= rx;
               default: ;
            endcase
            // Year arrives last and goes straight out with the shadowed bytes.
            if (idx == 3'd6) begin
               read_second <= sd_sec;
               read_minute <= sd_min;
               read_hour   <= sd_hour;
               read_date   <= sd_date;
               read_month  <= sd_month;
               read_week   <= sd_week;
               read_year   <= rx;
            end
         end
      end
   end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Bench for ds1302_ctrl: behavioural DS1302 slave, frame and ack scoreboards
// fed from a register-array model of the chip contents.
module tb_ds1302_ctrl;

   localparam int CLK_DIV = 4;
   localparam int CE_GAP  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ds1302_ce, ds1302_sclk;
   wire        ds1302_io;
   logic       write_time_req, read_time_req;
   logic [7:0] write_second, write_minute, write_hour, write_date;
   logic [7:0] write_month, write_week, write_year;
   logic       write_time_ack, read_time_ack;
   logic [7:0] read_second, read_minute, read_hour, read_date;
   logic [7:0] read_month, read_week, read_year;

   int n_chk  = 0;
   int n_fail = 0;
   bit abort  = 1'b0;

   logic [15:0] frame_q[$];
   logic [56:0] ack_q[$];
   logic [7:0]  pred[7] = '{8'h59, 8'h30, 8'h12, 8'h31, 8'h12, 8'h07, 8'h24};
   logic [55:0] held = '0;

   ds1302_ctrl #(.CLK_DIV(CLK_DIV), .CE_GAP(CE_GAP)) dut (
      .clk(clk), .rst(rst),
      .ds1302_ce(ds1302_ce), .ds1302_sclk(ds1302_sclk), .ds1302_io(ds1302_io),
      .write_time_req(write_time_req),
      .write_second(write_second), .write_minute(write_minute), .write_hour(write_hour),
      .write_date(write_date), .write_month(write_month), .write_week(write_week),
      .write_year(write_year), .write_time_ack(write_time_ack),
      .read_time_req(read_time_req),
      .read_second(read_second), .read_minute(read_minute), .read_hour(read_hour),
      .read_date(read_date), .read_month(read_month), .read_week(read_week),
      .read_year(read_year), .read_time_ack(read_time_ack)
   );

   always #5 clk = ~clk;

   // ---------------- DS1302 slave model ----------------
   logic        slv_oe  = 1'b0;
   logic        slv_out = 1'b0;
   logic [7:0]  slv_mem[8] = '{8'h59, 8'h30, 8'h12, 8'h31, 8'h12, 8'h07, 8'h24, 8'h80};
   int          slv_bits = 0;
   logic [15:0] slv_frame = '0;

   pullup (ds1302_io);
   assign ds1302_io = slv_oe ? slv_out : 1'bz;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge ds1302_ce) begin
      slv_bits  = 0;
      slv_frame = '0;
   end

   always @(posedge ds1302_sclk) begin
      if (ds1302_ce) begin
         if (slv_bits < 16) slv_frame[slv_bits] = ds1302_io;
         slv_bits++;
      end
   end

   always @(negedge ds1302_sclk) begin
      if (ds1302_ce && slv_frame[0] && slv_bits >= 8 && slv_bits < 16) begin
         logic [7:0] rd_byte;
         int         b;
         rd_byte = slv_mem[slv_frame[3:1]];
         b = slv_bits - 8;
         if (slv_bits == 8) begin
            #1;
            if (!abort) check("io_released_after_cmd", 64'(ds1302_io), 64'd1);
         end
         #1;
         if (ds1302_ce) begin
            slv_oe  = 1'b1;
            slv_out = rd_byte[b];
         end
      end
   end

   // Frame scoreboard: each CE pulse must carry the next expected {data, cmd}.
   always @(negedge ds1302_ce) begin
      logic [15:0] e;
      slv_oe = 1'b0;
      if (!abort) begin
         if (slv_bits == 16 && !slv_frame[0]) slv_mem[slv_frame[3:1]] = slv_frame[15:8];
         check("frame_rises", 64'(slv_bits), 64'd16);
         if (frame_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_unexpected: actual %0h required none", slv_frame);
         end else begin
            e = frame_q.pop_front();
            check("frame_cmd_data", 64'(slv_frame), 64'(e));
         end
      end
   end

   // CE low time between frames.
   int   ce_low_cnt = 1000;
   logic ce_prev    = 1'b0;
   always @(negedge clk) begin
      if (ds1302_ce && !ce_prev && !abort)
         check("ce_gap_min", 64'(ce_low_cnt >= CE_GAP), 64'd1);
      ce_low_cnt = ds1302_ce ? 0 : ce_low_cnt + 1;
      ce_prev    = ds1302_ce;
   end

   // Ack scoreboard plus hold check on the read outputs.
   logic wa_prev = 1'b0, ra_prev = 1'b0;
   always @(negedge clk) begin
      logic [55:0] rd_now;
      logic [56:0] e;
      rd_now = {read_second, read_minute, read_hour, read_date, read_month, read_week, read_year};
      if (write_time_ack || read_time_ack) begin
         check("ack_exclusive", 64'(write_time_ack & read_time_ack), 64'd0);
         check("ack_width", 64'((write_time_ack && wa_prev) || (read_time_ack && ra_prev)), 64'd0);
         if (ack_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_unexpected: actual w=%0d r=%0d required none", write_time_ack, read_time_ack);
         end else begin
            e = ack_q.pop_front();
            check("ack_kind_is_read", 64'(read_time_ack), 64'(e[56]));
            if (e[56]) begin
               check("read_values", 64'(rd_now), 64'(e[55:0]));
               held = e[55:0];
            end
         end
      end else begin
         check("read_hold", 64'(rd_now), 64'(held));
      end
      wa_prev = write_time_ack;
      ra_prev = read_time_ack;
   end

   // ---------------- driver tasks ----------------
   function automatic logic [7:0] rand_bcd(input int hi);
      int v;
      v = $urandom_range(hi, 0);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic set_inputs(input logic [7:0] s, m, h, d, mo, w, y);
      write_second = s;  write_minute = m; write_hour = h; write_date = d;
      write_month  = mo; write_week   = w; write_year = y;
   endtask

   task automatic set_random_inputs();
      set_inputs({1'($urandom_range(1, 0)), 7'(rand_bcd(59))}, rand_bcd(59), rand_bcd(23),
                 rand_bcd(31), rand_bcd(12), rand_bcd(7), rand_bcd(99));
   endtask

   task automatic push_write();
      logic [7:0] v[7];
      v = '{write_second, write_minute, write_hour, write_date, write_month, write_week, write_year};
      frame_q.push_back({8'h00, 8'h8E});
      for (int i = 0; i < 7; i++) begin
         pred[i] = (i == 0) ? (v[i] & 8'h7F) : v[i];
         frame_q.push_back({pred[i], 8'h80 + 8'(2 * i)});
      end
      ack_q.push_back({1'b0, 56'h0});
   endtask

   task automatic push_read();
      for (int i = 0; i < 7; i++) frame_q.push_back({pred[i], 8'h81 + 8'(2 * i)});
      ack_q.push_back({1'b1, pred[0], pred[1], pred[2], pred[3], pred[4], pred[5], pred[6]});
   endtask

   task automatic wait_ack(input bit want_read, input int budget);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (want_read ? read_time_ack : write_time_ack) return;
         n++;
         if (n >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: actual none required %s ack within %0d cycles",
                     want_read ? "read" : "write", budget);
            return;
         end
      end
   endtask

   task automatic run_write(input bit scramble);
      push_write();
      write_time_req = 1'b1;
      if (scramble) begin
         repeat (20) @(negedge clk);
         set_random_inputs();
      end
      wait_ack(1'b0, 3000);
      write_time_req = 1'b0;
   endtask

   task automatic run_read();
      push_read();
      read_time_req = 1'b1;
      wait_ack(1'b1, 3000);
      read_time_req = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      write_time_req = 1'b0;
      read_time_req  = 1'b0;
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("rst_ce", 64'(ds1302_ce), 64'd0);
      check("rst_sclk", 64'(ds1302_sclk), 64'd0);
      check("rst_io_released", 64'(ds1302_io), 64'd1);
      check("rst_acks", 64'({write_time_ack, read_time_ack}), 64'd0);
      check("rst_read_values", 64'({read_second, read_minute, read_hour, read_date,
                                    read_month, read_week, read_year}), 64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      run_read();
      set_inputs(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
      run_write(1'b0);
      run_read();

      // CH bit forced clear; inputs scrambled mid-sequence must not leak in.
      set_inputs(8'h85, 8'h44, 8'h21, 8'h15, 8'h09, 8'h03, 8'h30);
      run_write(1'b1);
      run_read();

      // Both requests together, read still pending after the write ack.
      set_random_inputs();
      push_write();
      push_read();
      write_time_req = 1'b1;
      read_time_req  = 1'b1;
      wait_ack(1'b0, 3000);
      write_time_req = 1'b0;
      wait_ack(1'b1, 3000);
      read_time_req = 1'b0;

      // Both requests together, read withdrawn before the write ack.
      set_random_inputs();
      push_write();
      write_time_req = 1'b1;
      read_time_req  = 1'b1;
      repeat (50) @(negedge clk);
      read_time_req = 1'b0;
      wait_ack(1'b0, 3000);
      write_time_req = 1'b0;
      repeat (400) @(negedge clk);

      // Write request held high: two back-to-back sequences.
      set_random_inputs();
      push_write();
      push_write();
      write_time_req = 1'b1;
      wait_ack(1'b0, 3000);
      wait_ack(1'b0, 3000);
      write_time_req = 1'b0;
      run_read();

      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(1, 0) == 1) begin
            set_random_inputs();
            run_write(1'b0);
         end else begin
            run_read();
         end
      end
      run_read();

      // Asynchronous reset in the middle of a read sequence.
      push_read();
      read_time_req = 1'b1;
      repeat ($urandom_range(250, 60)) @(negedge clk);
      abort = 1'b1;
      #2;
      rst = 1'b1;
      held = '0;
      frame_q.delete();
      ack_q.delete();
      read_time_req = 1'b0;
      #1;
      check("midrst_ce", 64'(ds1302_ce), 64'd0);
      check("midrst_sclk", 64'(ds1302_sclk), 64'd0);
      check("midrst_io_released", 64'(ds1302_io), 64'd1);
      check("midrst_acks", 64'({write_time_ack, read_time_ack}), 64'd0);
      check("midrst_read_values", 64'({read_second, read_minute, read_hour, read_date,
                                       read_month, read_week, read_year}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      abort = 1'b0;
      repeat (300) @(negedge clk);

      run_read();
      repeat (20) @(negedge clk);
      check("frames_left", 64'(frame_q.size()), 64'd0);
      check("acks_left", 64'(ack_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
